// File: rtl/multi_edge_detector_pkg.sv
// Shared constants for the multi-channel edge detector: per-channel mode
// encodings and a constant-evaluable clog2 for counter sizing.
package edge_pkg;
  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/multi_edge_detector_if.sv
// Bundle of per-channel inputs and detector outputs; the master drives the
// raw levels, modes and clears, the slave (detector) drives the results.
interface multi_edge_detector_if #(parameter int CHANNELS = 4);
  logic [CHANNELS-1:0]   inp;
  logic [2*CHANNELS-1:0] mode;
  logic [CHANNELS-1:0]   clr;
  logic [CHANNELS-1:0]   level_out;
  logic [CHANNELS-1:0]   posedge_out;
  logic [CHANNELS-1:0]   negedge_out;
  logic [CHANNELS-1:0]   event_out;
  logic [CHANNELS-1:0]   event_flag;
  logic                  irq;

  modport master (output inp, mode, clr,
                  input  level_out, posedge_out, negedge_out, event_out, event_flag, irq);
  modport slave  (input  inp, mode, clr,
                  output level_out, posedge_out, negedge_out, event_out, event_flag, irq);
endinterface

// File: rtl/multi_edge_detector_channel.sv
// One channel: synchroniser, consecutive-sample debounce, registered edge
// pulses, mode-qualified event pulse and sticky flag.
module edge_channel
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inp_i,
  input  logic [1:0] mode_i,
  input  logic       clr_i,
  output logic       level_o,
  output logic       posedge_o,
  output logic       negedge_o,
  output logic       event_o,
  output logic       flag_o
);
  localparam int CNT_W = clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_w;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic level_q, level_d, dly_q;
  logic pos_q, pos_d, neg_q, neg_d, ev_q, ev_d, flag_q, flag_d;

  // CDC: sync_q[0] samples the asynchronous input; plain flops, async clear only.
  always_ff @(posedge clk or negedge rst)
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], inp_i};

  assign s_w = sync_q[SYNC_STAGES-1];

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (s_w != level_q) begin
      if (cnt_q == CNT_LAST) level_d = s_w;
      else                   cnt_d   = cnt_q + 1'b1;
    end
    pos_d  = level_q & ~dly_q;
    neg_d  = ~level_q & dly_q;
    ev_d   = (pos_d & ((mode_i == MODE_RISE) || (mode_i == MODE_BOTH))) |
             (neg_d & ((mode_i == MODE_FALL) || (mode_i == MODE_BOTH)));
    // a new event wins over a simultaneous clear so nothing is lost
    flag_d = ev_d | (flag_q & ~clr_i);
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      dly_q   <= 1'b0;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
      ev_q    <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      dly_q   <= level_q;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      ev_q    <= ev_d;
      flag_q  <= flag_d;
    end

  assign level_o   = level_q;
  assign posedge_o = pos_q;
  assign negedge_o = neg_q;
  assign event_o   = ev_q;
  assign flag_o    = flag_q;
endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: CHANNELS independent edge_channel instances
// plus a registered OR of their sticky flags as irq.
module multi_edge_detector
  import edge_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  multi_edge_detector_if.slave  bus
);
  logic [CHANNELS-1:0] lvl_w, pos_w, neg_w, ev_w, flag_w;
  logic                irq_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    edge_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .inp_i     (bus.inp[c]),
      .mode_i    (bus.mode[2*c +: 2]),
      .clr_i     (bus.clr[c]),
      .level_o   (lvl_w[c]),
      .posedge_o (pos_w[c]),
      .negedge_o (neg_w[c]),
      .event_o   (ev_w[c]),
      .flag_o    (flag_w[c])
    );
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) irq_q <= 1'b0;
    else      irq_q <= |flag_w;

  assign bus.level_out   = lvl_w;
  assign bus.posedge_out = pos_w;
  assign bus.negedge_out = neg_w;
  assign bus.event_out   = ev_w;
  assign bus.event_flag  = flag_w;
  assign bus.irq         = irq_q;
endmodule

// File: tb/tb_multi_edge_detector.sv
// Scenario bench for multi_edge_detector with a sliding-window reference model.
module tb_multi_edge_detector;
  import edge_pkg::*;

  localparam int CH = 4;
  localparam int S  = 2;
  localparam int D  = 4;
  localparam int OW = 5*CH + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   ncmp = 0;
  int   nerr = 0;
  int   tcnt = 0;

  always #5 clk = ~clk;

  multi_edge_detector_if #(.CHANNELS(CH)) bus ();

  multi_edge_detector #(.CHANNELS(CH), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Model: samp[c][i] = raw input captured i edges ago. A new level is accepted
  // when the D synchronised samples ending now all differ from the current level.
  logic [S+D-1:0] samp [CH];
  logic [CH-1:0]  m_lvl, m_prev, m_pos, m_neg, m_ev, m_flag;
  logic           m_irq;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) samp[c] = '0;
    m_lvl = '0; m_prev = '0; m_pos = '0; m_neg = '0; m_ev = '0; m_flag = '0; m_irq = 1'b0;
  endtask

  task automatic step();
    logic [CH-1:0] nlvl, npos, nneg, nev, nflag;
    logic [D-1:0]  win;
    if (!rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < CH; c++) begin
      samp[c] = {samp[c][S+D-2:0], bus.inp[c]};
      win     = samp[c][S+D-1:S];
      nlvl[c] = (m_lvl[c] ? (win == '0) : (win == '1)) ? ~m_lvl[c] : m_lvl[c];
      npos[c] = m_lvl[c] & ~m_prev[c];
      nneg[c] = ~m_lvl[c] & m_prev[c];
      nev[c]  = (npos[c] & bus.mode[2*c]) | (nneg[c] & bus.mode[2*c+1]);
      nflag[c] = nev[c] | (m_flag[c] & ~bus.clr[c]);
    end
    m_irq  = |m_flag;
    m_prev = m_lvl;
    m_lvl  = nlvl;
    m_pos  = npos;
    m_neg  = nneg;
    m_ev   = nev;
    m_flag = nflag;
  endtask

  task automatic tick();
    @(posedge clk);
    step();
    #1;
    tcnt++;
  endtask

  function automatic logic [OW-1:0] obs();
    return {bus.level_out, bus.posedge_out, bus.negedge_out, bus.event_out, bus.event_flag, bus.irq};
  endfunction

  function automatic logic [OW-1:0] expv();
    return {m_lvl, m_pos, m_neg, m_ev, m_flag, m_irq};
  endfunction

  task automatic test_reset();
    bus.inp  = 4'b0001;
    bus.mode = {MODE_OFF, MODE_BOTH, MODE_BOTH, MODE_RISE};
    bus.clr  = '0;
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      ncmp++;
      if (obs() !== '0) begin
        nerr++; $display("FAIL reset_hold t=%0d got=%h exp=0", tcnt, obs());
      end
    end
    rst = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      ncmp++;
      if (obs() !== expv()) begin
        nerr++; $display("FAIL reset_release t=%0d got=%h exp=%h", tcnt, obs(), expv());
      end
      if (k == 4 || k == 5) begin
        ncmp++;
        if (bus.level_out[0] !== (k == 5)) begin
          nerr++; $display("FAIL level_latency edge=%0d got=%b exp=%b", k, bus.level_out[0], k == 5);
        end
      end
      if (k == 6 || k == 7) begin
        ncmp++;
        if ({bus.posedge_out[0], bus.event_out[0], bus.event_flag[0], bus.irq} !== ((k == 6) ? 4'b1110 : 4'b0011)) begin
          nerr++; $display("FAIL pulse_latency edge=%0d got=%b", k,
                           {bus.posedge_out[0], bus.event_out[0], bus.event_flag[0], bus.irq});
        end
      end
    end
  endtask

  task automatic test_glitch();
    int np, nn;
    np = 0; nn = 0;
    bus.inp[1] = 1'b1;
    for (int k = 0; k < 13; k++) begin
      if (k == 3) bus.inp[1] = 1'b0;
      tick();
      ncmp++;
      if (obs() !== expv()) begin
        nerr++; $display("FAIL glitch t=%0d got=%h exp=%h", tcnt, obs(), expv());
      end
      np += int'(bus.posedge_out[1]);
    end
    ncmp++;
    if (np != 0 || bus.level_out[1] !== 1'b0) begin
      nerr++; $display("FAIL glitch_reject got_pulses=%0d level=%b exp=0/0", np, bus.level_out[1]);
    end
    np = 0;
    bus.inp[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k == 4) bus.inp[1] = 1'b0;
      tick();
      ncmp++;
      if (obs() !== expv()) begin
        nerr++; $display("FAIL min_pulse t=%0d got=%h exp=%h", tcnt, obs(), expv());
      end
      np += int'(bus.posedge_out[1]);
      nn += int'(bus.negedge_out[1]);
    end
    ncmp++;
    if (np != 1 || nn != 1) begin
      nerr++; $display("FAIL min_pulse_count got=%0d/%0d exp=1/1", np, nn);
    end
  endtask

  task automatic test_sticky();
    int ne;
    ne = 0;
    bus.inp[2] = 1'b1;
    for (int k = 0; k < 22; k++) begin
      if (k == 10) bus.inp[2] = 1'b0;
      tick();
      ncmp++;
      if (obs() !== expv()) begin
        nerr++; $display("FAIL sticky t=%0d got=%h exp=%h", tcnt, obs(), expv());
      end
      ne += int'(bus.event_out[2]);
    end
    ncmp++;
    if (ne != 2 || bus.event_flag[2] !== 1'b1) begin
      nerr++; $display("FAIL sticky_events got=%0d flag=%b exp=2/1", ne, bus.event_flag[2]);
    end
    bus.clr[2] = 1'b1;
    tick();
    bus.clr[2] = 1'b0;
    ncmp++;
    if (bus.event_flag[2] !== 1'b0 || obs() !== expv()) begin
      nerr++; $display("FAIL sticky_clr got=%h exp=%h", obs(), expv());
    end
  endtask

  task automatic test_clr_collision();
    bus.clr = '1;
    bus.mode[1:0] = MODE_BOTH;
    tick();
    bus.clr = '0;
    bus.inp[0] = 1'b0;
    for (int k = 0; k < 9; k++) begin
      bus.clr[0] = (k == 6 || k == 7);
      tick();
      ncmp++;
      if (obs() !== expv()) begin
        nerr++; $display("FAIL collision t=%0d got=%h exp=%h", tcnt, obs(), expv());
      end
      if (k == 6) begin
        ncmp++;
        if ({bus.event_out[0], bus.event_flag[0]} !== 2'b11) begin
          nerr++; $display("FAIL set_beats_clr got=%b exp=11", {bus.event_out[0], bus.event_flag[0]});
        end
      end
      if (k == 8) begin
        ncmp++;
        if ({bus.event_flag[0], bus.irq} !== 2'b00) begin
          nerr++; $display("FAIL clr_then_irq got=%b exp=00", {bus.event_flag[0], bus.irq});
        end
      end
    end
    bus.clr = '0;
  endtask

  task automatic test_reset_mid();
    logic [CH-1:0] acc;
    bus.inp[2] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 8) bus.inp[1] = 1'b1;
      tick();
      ncmp++;
      if (obs() !== expv()) begin
        nerr++; $display("FAIL mid_setup t=%0d got=%h exp=%h", tcnt, obs(), expv());
      end
    end
    #2 rst = 1'b0;
    model_reset();
    #1;
    ncmp++;
    if (obs() !== '0) begin
      nerr++; $display("FAIL async_reset got=%h exp=0", obs());
    end
    bus.inp = '0;
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b1;
    acc = '0;
    for (int k = 0; k < 12; k++) begin
      tick();
      ncmp++;
      if (obs() !== expv()) begin
        nerr++; $display("FAIL post_reset t=%0d got=%h exp=%h", tcnt, obs(), expv());
      end
      acc |= bus.posedge_out | bus.negedge_out;
    end
    ncmp++;
    if (acc !== '0) begin
      nerr++; $display("FAIL reset_no_pulse got=%b exp=0", acc);
    end
  endtask

  task automatic test_mode_off();
    int np, ne;
    np = 0; ne = 0;
    bus.inp[3] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 2) bus.mode[1:0] = MODE_FALL;
      tick();
      ncmp++;
      if (obs() !== expv()) begin
        nerr++; $display("FAIL mode_off t=%0d got=%h exp=%h", tcnt, obs(), expv());
      end
      np += int'(bus.posedge_out[3]);
      ne += int'(bus.event_out[3]) + int'(bus.event_flag[3]) + int'(bus.irq);
    end
    ncmp++;
    if (np != 1 || ne != 0) begin
      nerr++; $display("FAIL mode_off_gate got=%0d/%0d exp=1/0", np, ne);
    end
  endtask

  task automatic test_random();
    int hold [CH];
    for (int c = 0; c < CH; c++) hold[c] = 1;
    for (int k = 0; k < 800; k++) begin
      for (int c = 0; c < CH; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          bus.inp[c] = ~bus.inp[c];
          hold[c] = int'($urandom_range(1, 8));
        end
        bus.clr[c] = ($urandom_range(0, 9) == 0);
      end
      if ($urandom_range(0, 19) == 0) bus.mode = 8'($urandom);
      tick();
      ncmp++;
      if (obs() !== expv()) begin
        nerr++; $display("FAIL random t=%0d got=%h exp=%h", tcnt, obs(), expv());
      end
    end
    bus.clr = '0;
  endtask

  initial begin
    bus.inp = '0; bus.mode = '0; bus.clr = '0;
    test_reset();
    test_glitch();
    test_sticky();
    test_clr_collision();
    test_reset_mid();
    test_mode_off();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
